cdb_arbiter: RTL and testbench

Shares the single common data bus (CDB) between three result producers: the RS/ALU path, the load-store buffer, and the branch unit. Each producer has a small FIFO, so results that lose arbitration are buffered rather than dropped. A round-robin grant selects one result per cycle, and the CDB outputs are registered for broadcast to the RS, LSB and ROB.

---
 rtl/cdb_arbiter.sv | 150 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three buffered result sources share one registered CDB
// through a round-robin grant (alu, lsb, brn).
module cdb_arbiter #(
  parameter int unsigned ID_WIDTH  = 4,
  parameter int unsigned VAL_WIDTH = 32,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 alu_valid,
  input  logic [ID_WIDTH-1:0]  alu_lab,
  input  logic [VAL_WIDTH-1:0] alu_val,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [ID_WIDTH-1:0]  lsb_lab,
  input  logic [VAL_WIDTH-1:0] lsb_val,
  output logic                 lsb_ready,
  input  logic                 brn_valid,
  input  logic [ID_WIDTH-1:0]  brn_lab,
  input  logic [VAL_WIDTH-1:0] brn_val,
  output logic                 brn_ready,
  output logic                 cdb_en,
  output logic [ID_WIDTH-1:0]  cdb_lab,
  output logic [VAL_WIDTH-1:0] cdb_val,
  output logic                 busy
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [ID_WIDTH-1:0]  lab_mem [3][DEPTH];
  logic [VAL_WIDTH-1:0] val_mem [3][DEPTH];
  logic [PtrW-1:0]      head    [3];
  logic [PtrW-1:0]      tail    [3];
  logic [CntW-1:0]      count   [3];
  logic [ID_WIDTH-1:0]  in_lab  [3];
  logic [VAL_WIDTH-1:0] in_val  [3];

  logic [2:0]           in_valid, ready, push, pop, nonempty;
  logic [1:0]           rr_ptr, gnt_idx, rr_next;
  logic                 gnt_found;
  logic [2:0]           cand;
  logic [ID_WIDTH-1:0]  gnt_lab;
  logic [VAL_WIDTH-1:0] gnt_val;

  always_comb begin
    in_valid  = {brn_valid, lsb_valid, alu_valid};
    in_lab[0] = alu_lab;
    in_lab[1] = lsb_lab;
    in_lab[2] = brn_lab;
    in_val[0] = alu_val;
    in_val[1] = lsb_val;
    in_val[2] = brn_val;
  end

  // Ready depends only on stored count, so a same-edge pop never frees a slot early.
  always_comb begin
    ready    = '0;
    nonempty = '0;
    push     = '0;
    for (int i = 0; i < 3; i++) begin
      ready[i]    = (count[i] != Full);
      nonempty[i] = (count[i] != '0);
      push[i]     = rdy_in & ~flush & in_valid[i] & ready[i] & (in_lab[i] != '0);
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 3'd0;
    for (int k = 0; k < 3; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (!gnt_found && nonempty[cand[1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[1:0];
      end
    end
    rr_next = (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
    gnt_lab = lab_mem[gnt_idx][head[gnt_idx]];
    gnt_val = val_mem[gnt_idx][head[gnt_idx]];
    pop     = '0;
    for (int i = 0; i < 3; i++) begin
      pop[i] = rdy_in & ~flush & gnt_found & (gnt_idx == 2'(i));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) begin
        lab_mem[i][tail[i]] <= in_lab[i];
        val_mem[i][tail[i]] <= in_val[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 3; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
      rr_ptr  <= 2'd0;
      cdb_en  <= 1'b0;
      cdb_lab <= '0;
      cdb_val <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        for (int i = 0; i < 3; i++) begin
          head[i]  <= '0;
          tail[i]  <= '0;
          count[i] <= '0;
        end
        rr_ptr  <= 2'd0;
        cdb_en  <= 1'b0;
        cdb_lab <= '0;
        cdb_val <= '0;
      end else begin
        for (int i = 0; i < 3; i++) begin
          if (push[i]) tail[i] <= tail[i] + PtrW'(1);
          if (pop[i])  head[i] <= head[i] + PtrW'(1);
          case ({push[i], pop[i]})
            2'b10:   count[i] <= count[i] + CntW'(1);
            2'b01:   count[i] <= count[i] - CntW'(1);
            default: count[i] <= count[i];
          endcase
        end
        if (gnt_found) begin
          cdb_en  <= 1'b1;
          cdb_lab <= gnt_lab;
          cdb_val <= gnt_val;
          rr_ptr  <= rr_next;
        end else begin
          cdb_en <= 1'b0;
        end
      end
    end
  end

  assign alu_ready = ready[0];
  assign lsb_ready = ready[1];
  assign brn_ready = ready[2];
  assign busy      = (|nonempty) | cdb_en;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios with a broadcast scoreboard.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [3:0]  lab;
    logic [31:0] val;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush;
  logic        alu_valid, lsb_valid, brn_valid;
  logic [3:0]  alu_lab, lsb_lab, brn_lab;
  logic [31:0] alu_val, lsb_val, brn_val;
  logic        alu_ready, lsb_ready, brn_ready;
  logic        cdb_en, busy;
  logic [3:0]  cdb_lab;
  logic [31:0] cdb_val;

  int   errors = 0;
  int   checks = 0;
  ent_t exp_q[$];
  ent_t mon_e;
  bit   mon_live;

  always #5 clk = ~clk;

  cdb_arbiter #(.ID_WIDTH(4), .VAL_WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .alu_valid(alu_valid), .alu_lab(alu_lab), .alu_val(alu_val), .alu_ready(alu_ready),
    .lsb_valid(lsb_valid), .lsb_lab(lsb_lab), .lsb_val(lsb_val), .lsb_ready(lsb_ready),
    .brn_valid(brn_valid), .brn_lab(brn_lab), .brn_val(brn_val), .brn_ready(brn_ready),
    .cdb_en(cdb_en), .cdb_lab(cdb_lab), .cdb_val(cdb_val), .busy(busy)
  );

  function automatic ent_t mk(input logic [3:0] l);
    return ent_t'{lab: l, val: 32'hC0DE_0000 + 32'(l)};
  endfunction

  // A fresh broadcast is one produced by a live edge; compare it against the queue head.
  always @(posedge clk) begin
    mon_live = rdy_in && !flush && !rst_in;
    #1;
    if (mon_live && cdb_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cdb_unexpected: got lab=%0d val=%h, required no broadcast",
                 cdb_lab, cdb_val);
      end else begin
        mon_e = exp_q.pop_front();
        if (cdb_lab !== mon_e.lab || cdb_val !== mon_e.val) begin
          errors++;
          $display("FAIL cdb_order: got lab=%0d val=%h, required lab=%0d val=%h",
                   cdb_lab, cdb_val, mon_e.lab, mon_e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsb_valid = 0; brn_valid = 0;
    alu_lab = 0; lsb_lab = 0; brn_lab = 0;
    alu_val = 0; lsb_val = 0; brn_val = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rdy_in = 1; flush = 0; rst_in = 1;
    exp_q.delete();
    tick();
    tick();
    rst_in = 0;
  endtask

  task automatic drive(input int src, input logic [3:0] l);
    ent_t e;
    e = mk(l);
    case (src)
      0: begin alu_valid = 1; alu_lab = e.lab; alu_val = e.val; end
      1: begin lsb_valid = 1; lsb_lab = e.lab; lsb_val = e.val; end
      default: begin brn_valid = 1; brn_lab = e.lab; brn_val = e.val; end
    endcase
  endtask

  task automatic test_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_lost: %0d results never broadcast, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rdy_in = 1; flush = 0; rst_in = 1;
    #2;
    checks++;
    if ({alu_ready, lsb_ready, brn_ready, busy, cdb_en} !== 5'b11100 || cdb_lab !== 4'd0 ||
        cdb_val !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b%b%b busy=%b en=%b lab=%0d val=%h, required 111 0 0 0 0",
               alu_ready, lsb_ready, brn_ready, busy, cdb_en, cdb_lab, cdb_val);
    end
    tick();
    rst_in = 0;
  endtask

  task automatic test_single();
    do_reset();
    drive(0, 4'd3);
    alu_val = 32'h11;
    exp_q.push_back(ent_t'{lab: 4'd3, val: 32'h11});
    tick();
    idle_inputs();
    checks++;
    if (cdb_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_no_bypass: en=%b busy=%b, required en=0 busy=1", cdb_en, busy);
    end
    tick();
    checks++;
    if (cdb_en !== 1'b1 || cdb_lab !== 4'd3 || cdb_val !== 32'h11) begin
      errors++;
      $display("FAIL single_bcast: en=%b lab=%0d val=%h, required 1 3 11", cdb_en, cdb_lab, cdb_val);
    end
    tick();
    checks++;
    if (cdb_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: en=%b busy=%b, required 0 0", cdb_en, busy);
    end
    test_queue_empty("single");
  endtask

  task automatic test_all_three();
    logic [3:0] want;
    do_reset();
    drive(0, 4'd1); drive(1, 4'd2); drive(2, 4'd3);
    exp_q.push_back(mk(4'd1)); exp_q.push_back(mk(4'd2)); exp_q.push_back(mk(4'd3));
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      tick();
      want = 4'(c + 1);
      checks++;
      if (cdb_en !== 1'b1 || cdb_lab !== want) begin
        errors++;
        $display("FAIL rr_cycle%0d: en=%b lab=%0d, required en=1 lab=%0d", c, cdb_en, cdb_lab, want);
      end
    end
    // Pointer must be back at alu: alu and brn offered together, alu wins.
    drive(2, 4'd9); drive(0, 4'd8);
    exp_q.push_back(mk(4'd8)); exp_q.push_back(mk(4'd9));
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    checks++;
    if (cdb_en !== 1'b0) begin
      errors++;
      $display("FAIL rr_drain: en=%b, required 0", cdb_en);
    end
    test_queue_empty("rr");
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(0, 4'd4); drive(1, 4'd7);
    exp_q.push_back(mk(4'd4)); exp_q.push_back(mk(4'd7)); exp_q.push_back(mk(4'd5));
    exp_q.push_back(mk(4'd6)); exp_q.push_back(mk(4'd10));
    tick();
    idle_inputs();
    drive(0, 4'd5);
    tick();
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_one: alu_ready=%b, required 1", alu_ready);
    end
    drive(0, 4'd6);
    tick();
    checks++;
    if (alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: alu_ready=%b, required 0", alu_ready);
    end
    // Held while not ready: must be taken exactly once, on the edge after space opens.
    drive(0, 4'd10);
    tick();
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_reopen: alu_ready=%b, required 1", alu_ready);
    end
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (cdb_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: en=%b busy=%b, required 0 0", cdb_en, busy);
    end
    test_queue_empty("b2b");
  endtask

  task automatic test_stall();
    do_reset();
    for (int l = 11; l <= 15; l++) exp_q.push_back(mk(4'(l)));
    drive(0, 4'd11); drive(1, 4'd12);
    tick();
    idle_inputs();
    drive(0, 4'd14); drive(2, 4'd13);
    tick();
    idle_inputs();
    drive(0, 4'd15);
    tick();
    idle_inputs();
    rdy_in = 0;
    drive(0, 4'd6);
    for (int c = 0; c < 5; c++) begin
      flush = (c == 2);
      tick();
      checks++;
      if (cdb_en !== 1'b1 || cdb_lab !== 4'd12 || alu_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_frozen%0d: en=%b lab=%0d alu_ready=%b busy=%b, required 1 12 0 1",
                 c, cdb_en, cdb_lab, alu_ready, busy);
      end
    end
    flush = 0;
    idle_inputs();
    rdy_in = 1;
    tick();
    checks++;
    if (cdb_lab !== 4'd13) begin
      errors++;
      $display("FAIL stall_resume: lab=%0d, required 13", cdb_lab);
    end
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (cdb_en !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: en=%b, required 0", cdb_en);
    end
    test_queue_empty("stall");
  endtask

  task automatic test_flush();
    do_reset();
    exp_q.push_back(mk(4'd1));
    drive(0, 4'd1); drive(1, 4'd2); drive(2, 4'd3);
    tick();
    idle_inputs();
    drive(0, 4'd4);
    tick();
    idle_inputs();
    drive(0, 4'd5);
    flush = 1;
    tick();
    flush = 0;
    idle_inputs();
    checks++;
    if (cdb_en !== 1'b0 || cdb_lab !== 4'd0 || cdb_val !== 32'd0 || busy !== 1'b0 ||
        {alu_ready, lsb_ready, brn_ready} !== 3'b111) begin
      errors++;
      $display("FAIL flush_clear: en=%b lab=%0d val=%h busy=%b ready=%b%b%b, required 0 0 0 0 111",
               cdb_en, cdb_lab, cdb_val, busy, alu_ready, lsb_ready, brn_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (cdb_en !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet%0d: en=%b, required 0", c, cdb_en);
      end
    end
    test_queue_empty("flush");
  endtask

  task automatic test_zero_label_and_async_reset();
    do_reset();
    drive(0, 4'd0);
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready_pre: alu_ready=%b, required 1", alu_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (alu_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_not_stored: alu_ready=%b busy=%b, required 1 0", alu_ready, busy);
    end
    tick();
    checks++;
    if (cdb_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_no_bcast: en=%b, required 0", cdb_en);
    end
    exp_q.push_back(mk(4'd9));
    drive(0, 4'd9);
    tick();
    idle_inputs();
    tick();
    checks++;
    if (cdb_en !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: en=%b busy=%b, required 1 1", cdb_en, busy);
    end
    #3 rst_in = 1;
    #1;
    checks++;
    if (cdb_en !== 1'b0 || busy !== 1'b0 || cdb_lab !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: en=%b busy=%b lab=%0d, required 0 0 0", cdb_en, busy, cdb_lab);
    end
    #1 rst_in = 0;
    tick();
    test_queue_empty("async");
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_back_to_back();
    test_stall();
    test_flush();
    test_zero_label_and_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
